// File: rtl/arb_pkg.sv
// Shared types and round-robin pick helper for the stream arbiter.
// Builds with or without ARB_GRANT_CNT_EN.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_REQ = 32;

  // Returns {found, idx}; scans ptr, ptr+1, ... mod n.
  function automatic logic [5:0] rr_pick(
    input logic [31:0] valid,
    input logic [4:0]  ptr,
    input int          n
  );
    logic [5:0] r;
    int k;
    r = '0;
    for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (valid[k[4:0]]) r = {1'b1, k[4:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first valid at or after ptr_i.
// Pure combinational, shared by all arbiter builds.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int num_req_p = 4,
  localparam int idw = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] valid_i,
  input  logic [idw-1:0]       ptr_i,
  output logic [idw-1:0]       idx_o,
  output logic                 any_o
);

  logic [5:0] res;

  assign res   = rr_pick(32'(valid_i), 5'(ptr_i), num_req_p);
  assign idx_o = res[idw-1:0];
  assign any_o = res[5];

  if (idw < 5) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^res[4:idw];
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin ready/valid merge with grant lock while stalled.
// Optional per-requester beat counters under ARB_GRANT_CNT_EN.
module stream_rr_arbiter
  import arb_pkg::*;
#(
  parameter int width_p     = 8,
  parameter int num_req_p   = 4,
  parameter int cnt_width_p = 16,
  localparam int idw = $clog2(num_req_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         valid_i,
  input  logic [num_req_p*width_p-1:0] data_i,
  output logic [num_req_p-1:0]         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic [idw-1:0]               grant_id_o,
  input  logic                         ready_i
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [num_req_p*cnt_width_p-1:0] grant_cnt_o
`endif
);

  arb_state_e     state_r;
  logic [idw-1:0] ptr_r;
  logic [idw-1:0] held_r;
  logic [idw-1:0] pick_idx;
  logic           pick_any;
  logic [idw-1:0] win;
  logic           vld;
  logic           hs;
  logic [width_p-1:0] data_sel;

  rr_priority_pick #(
    .num_req_p(num_req_p)
  ) u_pick (
    .valid_i(valid_i),
    .ptr_i  (ptr_r),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    win = pick_idx;
    vld = pick_any;
    if (state_r == ARB_HOLD) begin
      win = held_r;
      vld = valid_i[held_r];
    end
  end

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (win == idw'(k)) data_sel = data_i[k*width_p +: width_p];
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    valid_o    = 1'b0;
    ready_o    = '0;
    data_o     = '0;
    grant_id_o = '0;
    if (!reset_i && vld) begin
      valid_o      = 1'b1;
      data_o       = data_sel;
      grant_id_o   = win;
      ready_o[win] = ready_i;
    end
  end

  assign hs = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ARB_IDLE;
      ptr_r   <= '0;
      held_r  <= '0;
    end else if (hs) begin
      state_r <= ARB_IDLE;
      ptr_r   <= (win == idw'(num_req_p - 1)) ? '0 : win + 1'b1;
    end else if (state_r == ARB_IDLE && vld) begin
      state_r <= ARB_HOLD;
      held_r  <= win;
    end else if (state_r == ARB_HOLD && !vld) begin
      state_r <= ARB_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && state_r == ARB_HOLD) begin
      hold_drop: assert (valid_i[held_r]);
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [num_req_p-1:0][cnt_width_p-1:0] cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (hs && cnt_r[win] != '1) begin
      cnt_r[win] <= cnt_r[win] + 1'b1;
    end
  end

  assign grant_cnt_o = reset_i ? '0 : cnt_r;
`else
  localparam int unused_cnt_w = cnt_width_p;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (4 requesters, 8-bit data).
// Add ARB_GRANT_CNT_EN to also check saturating 2-bit counters.
module tb_stream_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       rdy;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] erdy;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  valid_i = '0;
  logic [31:0] data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [1:0]  grant_id_o;
  logic        ready_i = 1'b0;
`ifdef ARB_GRANT_CNT_EN
  logic [7:0]  grant_cnt_o;
`endif

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  int   m_cnt[4] = '{0, 0, 0, 0};

  always #5 clk_i = ~clk_i;

  stream_rr_arbiter #(
    .width_p(8),
    .num_req_p(4),
    .cnt_width_p(2)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .grant_id_o(grant_id_o),
    .ready_i   (ready_i)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o(grant_cnt_o)
`endif
  );

  function automatic void add(
    input logic rst, input logic [3:0] v, input logic rdy,
    input logic ev, input logic [1:0] eid, input logic [3:0] erdy
  );
    vec_t t;
    t.rst = rst; t.v = v; t.rdy = rdy;
    t.ev = ev; t.eid = eid; t.erdy = erdy;
    tbl.push_back(t);
  endfunction

  task automatic apply(input vec_t t);
    @(posedge clk_i);
    #1;
    reset_i = t.rst;
    valid_i = t.v;
    ready_i = t.rdy;
    exp_q.push_back(t);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic [7:0] ed;
      logic [1:0] gid;
      e = exp_q.pop_front();
      ed = e.ev ? (8'hA0 + 8'(e.eid)) : 8'h00;
      gid = e.ev ? e.eid : 2'd0;
      checks++;
      if (valid_o !== e.ev || grant_id_o !== gid ||
          ready_o !== e.erdy || data_o !== ed) begin
        errors++;
        $display("FAIL vec%0d: got v=%b id=%0d rdy=%b d=%h want v=%b id=%0d rdy=%b d=%h",
                 checks, valid_o, grant_id_o, ready_o, data_o,
                 e.ev, gid, e.erdy, ed);
      end
      if (e.rst) begin
        m_cnt = '{0, 0, 0, 0};
      end else if (e.ev && e.rdy && m_cnt[e.eid] < 3) begin
        m_cnt[e.eid]++;
      end
    end
  end

  initial begin
    add(1, 4'b1111, 1, 0, 0, 4'b0000);
    add(1, 4'b1111, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++)
      add(0, 4'b1111, 1, 1, 2'(i % 4), 4'b0001 << (i % 4));
    for (int i = 0; i < 3; i++)
      add(0, 4'b0100, 0, 1, 2, 4'b0000);
    add(0, 4'b0101, 0, 1, 2, 4'b0000);
    add(0, 4'b0101, 1, 1, 2, 4'b0100);
    add(0, 4'b0001, 1, 1, 0, 4'b0001);
    add(0, 4'b0100, 1, 1, 2, 4'b0100);
    add(0, 4'b1001, 1, 1, 3, 4'b1000);
    add(0, 4'b1001, 1, 1, 0, 4'b0001);
    add(0, 4'b0000, 1, 0, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 1, 1, 1, 4'b0010);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset pulsed while requester 3 is held
    begin
      vec_t t;
      t = '{rst: 0, v: 4'b1000, rdy: 0, ev: 1, eid: 3, erdy: 4'b0000};
      apply(t);
      t = '{rst: 1, v: 4'b1000, rdy: 0, ev: 0, eid: 0, erdy: 4'b0000};
      apply(t);
      t = '{rst: 0, v: 4'b1001, rdy: 1, ev: 1, eid: 0, erdy: 4'b0001};
      apply(t);
      for (int i = 0; i < 5; i++) begin
        t = '{rst: 0, v: 4'b0010, rdy: 1, ev: 1, eid: 1, erdy: 4'b0010};
        apply(t);
      end
      t = '{rst: 0, v: 4'b0000, rdy: 0, ev: 0, eid: 0, erdy: 4'b0000};
      apply(t);
    end

    @(negedge clk_i);
    #1;
`ifdef ARB_GRANT_CNT_EN
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant_cnt_o[k*2 +: 2] !== 2'(m_cnt[k])) begin
        errors++;
        $display("FAIL cnt%0d: got %0d want %0d",
                 k, grant_cnt_o[k*2 +: 2], m_cnt[k]);
      end
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
